// File: rtl/pulse_gen.sv
// pulse_gen: turns 1-cycle triggers into pulses of programmable width and gap
// Ports:
//   clk, rstn        clock and synchronous active-low reset
//   trig             one pulse request per cycle high
//   clr              synchronous flush of queue and current pulse
//   pol              0: idle low / pulse high, 1: idle high / pulse low
//   high_len,low_len active width and minimum gap in cycles (0 means 1)
//   Y                registered waveform
//   busy             pulse in progress or requests queued
//   pend_cnt         queued requests not yet started
//   ovf              one-cycle flag for a request dropped on a full queue
module pulse_gen #(
  parameter int CNT_W  = 16,
  parameter int PEND_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              trig,
  input  logic              clr,
  input  logic              pol,
  input  logic [CNT_W-1:0]  high_len,
  input  logic [CNT_W-1:0]  low_len,
  output logic              Y,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  logic [1:0]        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n, high_m1, low_m1;
  logic [PEND_W-1:0] pend_n;
  logic              free, go, high_done, ovf_n;
  always_comb begin
    high_m1   = (high_len == '0) ? '0 : high_len - 1'b1;
    low_m1    = (low_len == '0) ? '0 : low_len - 1'b1;
    // the last gap cycle may launch the next pulse directly, skipping IDLE
    free      = (state == IDLE) || (state == LOW && cnt == '0);
    go        = free && (trig || pend_cnt != '0);
    high_done = (state == HIGH) && (cnt == '0);
    state_n   = go ? HIGH : free ? IDLE : high_done ? LOW : state;
    cnt_n     = go ? high_m1 : high_done ? low_m1 : (cnt != '0) ? cnt - 1'b1 : '0;
    // a start with trig present swaps the new request for the queued one
    pend_n    = go ? ((pend_cnt != '0 && !trig) ? pend_cnt - 1'b1 : pend_cnt)
                   : (trig && pend_cnt != PEND_MAX) ? pend_cnt + 1'b1 : pend_cnt;
    ovf_n     = !go && trig && (pend_cnt == PEND_MAX);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      pend_cnt <= '0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      Y        <= 1'b0;
    end else if (clr) begin
      state    <= IDLE;
      cnt      <= '0;
      pend_cnt <= '0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      Y        <= pol;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pend_cnt <= pend_n;
      ovf      <= ovf_n;
      busy     <= (state_n != IDLE) || (pend_n != '0);
      Y        <= (state_n == HIGH) ^ pol;
    end
  end
endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: directed and random checks of pulse_gen against a timeline model
module tb_pulse_gen;
  localparam int CNT_W  = 16;
  localparam int PEND_W = 2;
  localparam int MAXP   = 3;
  localparam int BIG    = 32'h7fffffff;
  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              trig = 1'b0;
  logic              clr = 1'b0;
  logic              pol = 1'b0;
  logic [CNT_W-1:0]  high_len = 16'd3;
  logic [CNT_W-1:0]  low_len = 16'd2;
  logic              Y, busy, ovf;
  logic [PEND_W-1:0] pend_cnt;
  int checks = 0;
  int errors = 0;
  int e = 0, hs = 0, he = 0, ge = 0, mp = 0;
  logic ey = 1'b0, eb = 1'b0, eo = 1'b0, prev_y = 1'b0;
  int rises = 0, ovfs = 0;
  pulse_gen #(.CNT_W(CNT_W), .PEND_W(PEND_W)) dut (
    .clk(clk), .rstn(rstn), .trig(trig), .clr(clr), .pol(pol),
    .high_len(high_len), .low_len(low_len),
    .Y(Y), .busy(busy), .pend_cnt(pend_cnt), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Timeline model: pulse occupies edges [hs,he) active, then gap until ge;
  // ge stays unknown until the gap length is sampled at edge he.
  task automatic model();
    int hl, ll;
    e++;
    hl = (high_len == 0) ? 1 : int'(high_len);
    ll = (low_len == 0) ? 1 : int'(low_len);
    eo = 1'b0;
    if (!rstn || clr) begin
      mp = 0; hs = e; he = e; ge = e;
      ey = rstn ? pol : 1'b0;
      eb = 1'b0;
    end else begin
      if (e >= ge) begin
        if (trig || mp > 0) begin
          if (!trig) mp--;
          hs = e; he = e + hl; ge = BIG;
        end
      end else if (trig) begin
        if (mp == MAXP) eo = 1'b1;
        else mp++;
      end
      if (e == he && ge == BIG) ge = e + ll;
      ey = ((e >= hs && e < he) ? 1'b1 : 1'b0) ^ pol;
      eb = (e < ge) || (mp > 0);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model();
    #1;
    chk("y", Y, ey);
    chk("busy", busy, eb);
    chk("pend", pend_cnt, mp);
    chk("ovf", ovf, eo);
    if ((Y ^ pol) && !(prev_y)) rises++;
    prev_y = Y ^ pol;
    if (ovf) ovfs++;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  task automatic pulse();
    trig = 1'b1; cyc(); trig = 1'b0;
  endtask
  initial begin
    // 1: basic pulse after reset
    rstn = 1'b0; cyc();
    chk("rst_y", Y, 0); chk("rst_busy", busy, 0); chk("rst_pend", pend_cnt, 0); chk("rst_ovf", ovf, 0);
    rstn = 1'b1; cyc();
    pulse(); chk("t1_y_c1", Y, 1);
    run(2);  chk("t1_y_c3", Y, 1);
    cyc();   chk("t1_y_c4", Y, 0);
    run(2);  chk("t1_busy_c6", busy, 0);
    // 2: zero lengths behave as one
    high_len = 0; low_len = 0;
    pulse(); chk("t2_y_c1", Y, 1);
    cyc();   chk("t2_y_c2", Y, 0);
    cyc();   chk("t2_busy_c3", busy, 0);
    // 3: back-to-back queued pulses
    high_len = 2; low_len = 1; rises = 0;
    trig = 1'b1; cyc(); cyc(); chk("t3_pend1", pend_cnt, 1);
    cyc(); chk("t3_pend2", pend_cnt, 2);
    trig = 1'b0; run(8);
    chk("t3_rises", rises, 3); chk("t3_busy", busy, 0);
    // 4: queue saturation
    high_len = 20; rises = 0; ovfs = 0;
    pulse(); trig = 1'b1; run(5); trig = 1'b0;
    chk("t4_pend_sat", pend_cnt, 3);
    for (int i = 0; i < 200 && busy; i++) cyc();
    chk("t4_idle", busy, 0); chk("t4_rises", rises, 4); chk("t4_ovfs", ovfs, 2);
    // 5: clear mid-pulse
    high_len = 10;
    trig = 1'b1; run(3); trig = 1'b0;
    chk("t5_pend", pend_cnt, 2);
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("t5_y", Y, 0); chk("t5_pend0", pend_cnt, 0); chk("t5_busy", busy, 0);
    // 6: reset mid-gap with inverted polarity, then polarity toggle in IDLE
    pol = 1'b1; high_len = 1; low_len = 5;
    cyc(); pulse(); chk("t6_active", Y, 0);
    run(2); chk("t6_gap", Y, 1);
    trig = 1'b1; cyc(); trig = 1'b0;
    rstn = 1'b0; cyc(); chk("t6_rst_y", Y, 0);
    rstn = 1'b1; cyc(); chk("t6_post_y", Y, 1); chk("t6_pend", pend_cnt, 0);
    pol = 1'b0; cyc(); chk("t6_pol", Y, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      trig = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 59) == 0);
      rstn = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 39) == 0) pol = ~pol;
      high_len = CNT_W'($urandom_range(0, 4));
      low_len = CNT_W'($urandom_range(0, 3));
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
